// File: rtl/ahb_to_apb_bridge.sv
// rtl/ahb_to_apb_bridge.sv - AHB-Lite slave to APB3 master bridge
//
// Each accepted AHB transfer becomes exactly one APB setup/access sequence.
// The AHB data phase is held with wait states until the APB slave completes.
// Optional feature macro: APB_BRIDGE_SLVERR_EN
//   defined   : PSLVERR with PREADY in ACCESS gives a two-cycle AHB ERROR
//   undefined : PSLVERR is ignored and HRESP is tied low
//
// Ports:
//   HCLK, HRESETn               clock (rising edge), asynchronous active-low reset
//   HSEL, HADDR, HTRANS, HSIZE  AHB-Lite address phase
//   HPROT, HWRITE, HREADY
//   HWDATA                      AHB write data (data phase)
//   HREADYOUT, HRESP, HRDATA    AHB-Lite slave response
//   PSEL, PADDR, PENABLE,       APB3 request; PADDR[15:12] drives the
//   PWRITE, PWDATA, PSTRB,      peripheral decoder
//   PPROT
//   PRDATA, PREADY, PSLVERR     multiplexed APB slave response

module ahb_to_apb_bridge #(
    parameter int unsigned ADDRWIDTH = 16
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 HSEL,
    input  logic [ADDRWIDTH-1:0] HADDR,
    input  logic [1:0]           HTRANS,
    input  logic [2:0]           HSIZE,
    input  logic [3:0]           HPROT,
    input  logic                 HWRITE,
    input  logic                 HREADY,
    input  logic [31:0]          HWDATA,
    output logic                 HREADYOUT,
    output logic                 HRESP,
    output logic [31:0]          HRDATA,
    output logic                 PSEL,
    output logic [ADDRWIDTH-1:0] PADDR,
    output logic                 PENABLE,
    output logic                 PWRITE,
    output logic [31:0]          PWDATA,
    output logic [3:0]           PSTRB,
    output logic [2:0]           PPROT,
    input  logic [31:0]          PRDATA,
    input  logic                 PREADY,
    input  logic                 PSLVERR
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
`ifdef APB_BRIDGE_SLVERR_EN
        ST_ERR1   = 3'd5,
        ST_ERR2   = 3'd6,
`endif
        ST_DONE   = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;
    state_t start_state;
    logic   accept;

    // HREADYOUT is high exactly in IDLE, DONE and ERR2, which are the only
    // states allowed to accept a new address phase.
    assign accept = HREADYOUT & HSEL & HTRANS[1] & HREADY;

    // Writes detour through WAIT so HWDATA can be captured in the data phase.
    assign start_state = accept ? (HWRITE ? ST_WAIT : ST_SETUP) : ST_IDLE;

    function automatic logic [3:0] write_strobe(input logic [2:0] size,
                                                input logic [1:0] lsb);
        case (size)
            3'd0:    return 4'b0001 << lsb;
            3'd1:    return 4'b0011 << {lsb[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: state_nxt = start_state;
            ST_WAIT:          state_nxt = ST_SETUP;
            ST_SETUP:         state_nxt = ST_ACCESS;
            ST_ACCESS: begin
                if (PREADY) begin
`ifdef APB_BRIDGE_SLVERR_EN
                    state_nxt = PSLVERR ? ST_ERR1 : ST_DONE;
`else
                    state_nxt = ST_DONE;
`endif
                end
            end
`ifdef APB_BRIDGE_SLVERR_EN
            ST_ERR1:          state_nxt = ST_ERR2;
            ST_ERR2:          state_nxt = start_state;
`endif
            default:          state_nxt = ST_IDLE;
        endcase
    end

    // State and all handshake outputs are registered together; the outputs
    // are decoded from the next state so they line up with the state register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            HREADYOUT <= 1'b1;
`ifdef APB_BRIDGE_SLVERR_EN
            HRESP     <= 1'b0;
`endif
            HRDATA    <= 32'h0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= 32'h0;
            PSTRB     <= 4'h0;
            PPROT     <= 3'h0;
        end else begin
            state     <= state_nxt;
`ifdef APB_BRIDGE_SLVERR_EN
            HREADYOUT <= (state_nxt == ST_IDLE) || (state_nxt == ST_DONE) ||
                         (state_nxt == ST_ERR2);
            HRESP     <= (state_nxt == ST_ERR1) || (state_nxt == ST_ERR2);
`else
            HREADYOUT <= (state_nxt == ST_IDLE) || (state_nxt == ST_DONE);
`endif
            PSEL      <= (state_nxt == ST_SETUP) || (state_nxt == ST_ACCESS);
            PENABLE   <= (state_nxt == ST_ACCESS);

            // Address/control are only loaded on accept, so they stay stable
            // from SETUP through the final ACCESS cycle.
            if (accept) begin
                PADDR  <= HADDR;
                PWRITE <= HWRITE;
                PSTRB  <= HWRITE ? write_strobe(HSIZE, HADDR[1:0]) : 4'h0;
                PPROT  <= {~HPROT[0], 1'b0, HPROT[1]};
            end

            if (state == ST_WAIT) begin
                PWDATA <= HWDATA;
            end

            if ((state == ST_ACCESS) && PREADY && !PWRITE) begin
                HRDATA <= PRDATA;
            end
        end
    end

`ifdef APB_BRIDGE_SLVERR_EN
    logic unused_inputs;
    assign unused_inputs = &{1'b0, HTRANS[0], HPROT[3:2]};
`else
    assign HRESP = 1'b0;

    logic unused_inputs;
    assign unused_inputs = &{1'b0, HTRANS[0], HPROT[3:2], PSLVERR};
`endif

endmodule

// File: tb/tb_ahb_to_apb_bridge.sv
// tb/tb_ahb_to_apb_bridge.sv - scoreboard testbench for ahb_to_apb_bridge

module tb_ahb_to_apb_bridge;

`ifdef APB_BRIDGE_SLVERR_EN
    localparam bit SLVERR_EN = 1'b1;
`else
    localparam bit SLVERR_EN = 1'b0;
`endif

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [15:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;
    logic        HWRITE;
    logic        HREADY;
    logic [31:0] HWDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic        PSEL;
    logic [15:0] PADDR;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    assign HREADY = HREADYOUT;

    always #5 HCLK = ~HCLK;

    ahb_to_apb_bridge #(.ADDRWIDTH(16)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE),
        .HREADY(HREADY), .HWDATA(HWDATA), .HREADYOUT(HREADYOUT),
        .HRESP(HRESP), .HRDATA(HRDATA), .PSEL(PSEL), .PADDR(PADDR),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PPROT(PPROT), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    typedef struct {
        logic [15:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [3:0]  prot;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] rdata;
        logic        err;
        int          gap;
        logic        b2b;
    } xfer_t;

    xfer_t stim_q[$];
    xfer_t apb_q[$];
    xfer_t ahb_q[$];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event occurred with no expectation pending", name);
    endtask

    // Byte lanes covered by the transfer: the naturally aligned container of
    // 2**size bytes around the address.
    function automatic logic [3:0] exp_strb(input xfer_t t);
        int n;
        int base;
        logic [3:0] s;
        s = 4'h0;
        if (!t.write) return s;
        n = (t.size >= 3'd2) ? 4 : (1 << t.size);
        base = int'(t.addr[1:0]) - (int'(t.addr[1:0]) % n);
        for (int i = 0; i < 4; i++) begin
            if (i >= base && i < base + n) s[i] = 1'b1;
        end
        return s;
    endfunction

    function automatic int exp_waits(input xfer_t t);
        return (t.write ? 3 : 2) + t.waits + ((t.err && SLVERR_EN) ? 1 : 0);
    endfunction

    function automatic xfer_t mk(input logic [15:0] addr, input logic write,
                                 input logic [2:0] size, input logic [31:0] wdata,
                                 input int waits, input logic [31:0] rdata,
                                 input logic err, input int gap, input logic b2b);
        xfer_t t;
        t.addr  = addr;
        t.write = write;
        t.size  = size;
        t.prot  = 4'($urandom);
        t.wdata = wdata;
        t.waits = waits;
        t.rdata = rdata;
        t.err   = err;
        t.gap   = gap;
        t.b2b   = b2b;
        return t;
    endfunction

    // ---------------- AHB master driver ----------------
    task automatic drive_idle();
        case ($urandom_range(0, 2))
            0:       begin HSEL = 1'b0; HTRANS = 2'b10; end
            1:       begin HSEL = 1'b1; HTRANS = 2'b00; end
            default: begin HSEL = 1'b1; HTRANS = 2'b01; end
        endcase
        HADDR  = 16'($urandom);
        HWRITE = 1'($urandom);
        HSIZE  = 3'($urandom_range(0, 2));
        HPROT  = 4'($urandom);
    endtask

    task automatic present(input xfer_t t);
        HSEL   = 1'b1;
        HTRANS = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
        HADDR  = t.addr;
        HWRITE = t.write;
        HSIZE  = t.size;
        HPROT  = t.prot;
        apb_q.push_back(t);
        ahb_q.push_back(t);
    endtask

    task automatic run_stream();
        xfer_t cur;
        logic  rdy;
        bit    addr_valid;
        int    idle_left;
        int    guard;
        addr_valid = 1'b0;
        idle_left  = 0;
        guard      = 0;
        cur        = mk(16'h0, 1'b0, 3'd0, 32'h0, 0, 32'h0, 1'b0, 0, 1'b0);
        while ((addr_valid || stim_q.size() != 0) && guard < 3000) begin
            @(negedge HCLK);
            rdy = HREADYOUT;
            @(posedge HCLK);
            #1;
            guard++;
            if (rdy) begin
                if (addr_valid) begin
                    HWDATA = cur.write ? cur.wdata : $urandom;
                    addr_valid = 1'b0;
                end
                if (idle_left > 0 || stim_q.size() == 0) begin
                    drive_idle();
                    if (idle_left > 0) idle_left--;
                end else begin
                    cur = stim_q.pop_front();
                    present(cur);
                    addr_valid = 1'b1;
                    idle_left  = cur.gap;
                end
            end
        end
        check("stream_accepted", 64'(stim_q.size()) + 64'(addr_valid), 64'd0);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((ahb_q.size() != 0 || apb_q.size() != 0) && guard < 200) begin
            @(negedge HCLK);
            guard++;
        end
        repeat (2) @(negedge HCLK);
        check("drain_done", 64'(ahb_q.size() + apb_q.size()), 64'd0);
    endtask

    // ---------------- AHB response monitor ----------------
    bit    m_in_data;
    int    m_dcnt;
    int    m_resp_waits;
    xfer_t m_exp;
    logic  m_err;

    always @(negedge HCLK) begin
        if (!HRESETn) begin
            m_in_data = 1'b0;
        end else begin
            if (m_in_data) begin
                m_dcnt++;
                if (!HREADYOUT) begin
                    if (HRESP) m_resp_waits++;
                end else begin
                    if (ahb_q.size() == 0) begin
                        fail("ahb_unexpected_completion");
                    end else begin
                        m_exp = ahb_q.pop_front();
                        m_err = m_exp.err && SLVERR_EN;
                        check("ahb_wait_states", 64'(m_dcnt - 1), 64'(exp_waits(m_exp)));
                        check("ahb_hresp_final", 64'(HRESP), 64'(m_err));
                        check("ahb_hresp_wait_cycles", 64'(m_resp_waits), m_err ? 64'd1 : 64'd0);
                        if (!m_exp.write && !m_err)
                            check("ahb_hrdata", 64'(HRDATA), 64'(m_exp.rdata));
                    end
                    m_in_data = 1'b0;
                end
            end
            if (HREADYOUT && HSEL && HTRANS[1] && HREADY) begin
                m_in_data    = 1'b1;
                m_dcnt       = 0;
                m_resp_waits = 0;
            end
        end
    end

    // ---------------- APB slave model and monitor ----------------
    xfer_t       s_cur;
    bit          s_act;
    int          s_cnt;
    int          s_hi;
    int          s_gap;
    logic [55:0] s_snap;

    always @(negedge HCLK) begin
        if (!HRESETn) begin
            PREADY  = 1'b0;
            PSLVERR = 1'b0;
            PRDATA  = 32'h0;
            s_act   = 1'b0;
            s_gap   = 99;
        end else begin
            check("penable_implies_psel", 64'(PENABLE && !PSEL), 64'd0);
            if (PSEL && !PENABLE) begin
                if (apb_q.size() == 0) begin
                    fail("apb_unexpected_setup");
                end else begin
                    s_cur = apb_q.pop_front();
                    check("apb_paddr", 64'(PADDR), 64'(s_cur.addr));
                    check("apb_pwrite", 64'(PWRITE), 64'(s_cur.write));
                    check("apb_pstrb", 64'(PSTRB), 64'(exp_strb(s_cur)));
                    check("apb_pprot", 64'(PPROT),
                          64'({~s_cur.prot[0], 1'b0, s_cur.prot[1]}));
                    if (s_cur.write) check("apb_pwdata", 64'(PWDATA), 64'(s_cur.wdata));
                    if (s_cur.b2b) check("apb_b2b_psel_gap", 64'(s_gap), 64'd1);
                    s_act  = 1'b1;
                    s_cnt  = s_cur.waits;
                    s_hi   = 1;
                    s_snap = {PADDR, PWRITE, PWDATA, PSTRB, PPROT};
                end
                s_gap   = 0;
                PREADY  = 1'b0;
                PSLVERR = 1'b0;
            end else if (PSEL && PENABLE && s_act) begin
                s_hi++;
                check("apb_stable", 64'({PADDR, PWRITE, PWDATA, PSTRB, PPROT}), 64'(s_snap));
                if (s_cnt > 0) begin
                    PREADY  = 1'b0;
                    PSLVERR = 1'($urandom);
                    s_cnt--;
                end else begin
                    PREADY  = 1'b1;
                    PRDATA  = s_cur.rdata;
                    PSLVERR = s_cur.err;
                    s_act   = 1'b0;
                    check("apb_psel_cycles", 64'(s_hi), 64'(s_cur.waits + 2));
                end
            end else begin
                if (!PSEL) s_gap++;
                PREADY  = 1'($urandom);
                PSLVERR = 1'($urandom);
                PRDATA  = $urandom;
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        xfer_t t;
        int    prev_gap;
        bit    prev_err;
        int    guard;

        HRESETn = 1'b0;
        HSEL    = 1'b0;
        HTRANS  = 2'b00;
        HADDR   = 16'h0;
        HSIZE   = 3'd0;
        HPROT   = 4'h0;
        HWRITE  = 1'b0;
        HWDATA  = 32'h0;

        repeat (3) @(posedge HCLK);
        #1;
        check("rst_hreadyout", 64'(HREADYOUT), 64'd1);
        check("rst_hresp", 64'(HRESP), 64'd0);
        check("rst_hrdata", 64'(HRDATA), 64'd0);
        check("rst_psel", 64'(PSEL), 64'd0);
        check("rst_penable", 64'(PENABLE), 64'd0);
        check("rst_pwrite", 64'(PWRITE), 64'd0);
        check("rst_paddr", 64'(PADDR), 64'd0);
        check("rst_pwdata", 64'(PWDATA), 64'd0);
        check("rst_pstrb", 64'(PSTRB), 64'd0);
        check("rst_pprot", 64'(PPROT), 64'd0);
        HRESETn = 1'b1;

        // Directed cases
        stim_q.push_back(mk(16'h2004, 1'b0, 3'd2, 32'h0, 0, 32'hA5A5_1234, 1'b0, 1, 1'b0));
        stim_q.push_back(mk(16'h0000, 1'b1, 3'd2, 32'hDEAD_BEEF, 2, 32'h0, 1'b0, 1, 1'b0));
        stim_q.push_back(mk(16'h1003, 1'b1, 3'd0, 32'h1122_3344, 0, 32'h0, 1'b0, 1, 1'b0));
        stim_q.push_back(mk(16'h1002, 1'b1, 3'd1, 32'h5566_7788, 0, 32'h0, 1'b0, 1, 1'b0));
        stim_q.push_back(mk(16'h4000, 1'b0, 3'd2, 32'h0, 1, 32'h0BAD_0BAD, 1'b1, 1, 1'b0));
        stim_q.push_back(mk(16'h5000, 1'b0, 3'd2, 32'h0, 0, 32'h1357_9BDF, 1'b0, 0, 1'b0));
        stim_q.push_back(mk(16'h5004, 1'b0, 3'd2, 32'h0, 0, 32'h2468_ACE0, 1'b0, 1, 1'b1));
        run_stream();
        drain();

        // Randomized traffic
        prev_gap = 1;
        prev_err = 1'b0;
        for (int i = 0; i < 80; i++) begin
            t = mk(16'($urandom), 1'($urandom), 3'($urandom_range(0, 4)), $urandom,
                   int'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 4) == 0),
                   int'($urandom_range(0, 2)), 1'b0);
            t.b2b = (prev_gap == 0) && !t.write && !prev_err;
            prev_gap = t.gap;
            prev_err = t.err && SLVERR_EN;
            stim_q.push_back(t);
        end
        run_stream();
        drain();

        // Reset in the middle of an APB access
        stim_q.push_back(mk(16'h3000, 1'b0, 3'd2, 32'h0, 6, 32'h1111_2222, 1'b0, 1, 1'b0));
        run_stream();
        guard = 0;
        while (!(PSEL && PENABLE) && guard < 20) begin
            @(negedge HCLK);
            guard++;
        end
        check("rst_reached_access", 64'(PSEL && PENABLE), 64'd1);
        #2;
        HRESETn = 1'b0;
        #1;
        check("async_rst_psel", 64'(PSEL), 64'd0);
        check("async_rst_penable", 64'(PENABLE), 64'd0);
        check("async_rst_hresp", 64'(HRESP), 64'd0);
        check("async_rst_hreadyout", 64'(HREADYOUT), 64'd1);
        ahb_q.delete();
        apb_q.delete();
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        check("post_rst_hrdata", 64'(HRDATA), 64'd0);

        stim_q.push_back(mk(16'h2008, 1'b0, 3'd2, 32'h0, 0, 32'hCAFE_F00D, 1'b0, 1, 1'b0));
        run_stream();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
